// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline control blocks: register-field
// width, the hard-wired zero register and the hazard controller state encoding.
package cpu_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID-stage instruction that reads the register
// a load in EX is about to write. Writes to the zero register never hazard.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic             memread_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    output logic             load_use_o
);

    assign load_use_o = memread_i && (rd_i != ZERO_REG) &&
                        ((rd_i == rs_i) || (rd_i == rt_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, sticky error
// flag and saturating stall counter. Outputs are combinational from state+inputs.
//
//   state    | meaning
//   RUN      | no outstanding data-memory access
//   MEM_WAIT | load/store in MEM waiting for dmem_ready_i, pipeline frozen
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rd_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_e           state_q;
    logic [15:0]      wait_cnt_q;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic timeout;
    logic mem_stall;
    logic load_use;
    logic redirect;

    hazard_detect u_detect (
        .memread_i  (idex_memread_i),
        .rd_i       (idex_rd_i),
        .rs_i       (ifid_rs_i),
        .rt_i       (ifid_rt_i),
        .load_use_o (load_use)
    );

    assign timeout   = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST);
    assign mem_stall = ((state_q == RUN) && dmem_req_i && !dmem_ready_i) ||
                       ((state_q == MEM_WAIT) && !dmem_ready_i && !timeout);
    assign redirect  = branch_taken_i || jump_i;

    // Freeze wins over redirect: ID is held, so the redirect is re-presented later.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (mem_stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            freeze_o      = 1'b1;
        end else if (redirect) begin
            ifid_flush_o  = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (dmem_req_i && !dmem_ready_i) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    // A completion arriving on the last allowed cycle is not an error.
                    if (dmem_ready_i) begin
                        state_q <= RUN;
                    end else if (timeout) begin
                        state_q   <= RUN;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                default: state_q <= RUN;
            endcase
            if (!pc_write_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign mem_err_o   = mem_err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    // expected-output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, freeze}
    localparam logic [4:0] V_RESET  = 5'b00110;
    localparam logic [4:0] V_NORMAL = 5'b11000;
    localparam logic [4:0] V_REDIR  = 5'b11100;
    localparam logic [4:0] V_BUBBLE = 5'b00010;
    localparam logic [4:0] V_FREEZE = 5'b00001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          memread = 1'b0;
    logic [4:0]    rd = '0, rs = '0, rt = '0;
    logic          br = 1'b0, jmp = 1'b0, req = 1'b0, ready = 1'b0;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, freeze, mem_err;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit m_wait   = 1'b0;
    int m_waited = 0;
    bit m_err    = 1'b0;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .idex_memread_i (memread),
        .idex_rd_i      (rd),
        .ifid_rs_i      (rs),
        .ifid_rt_i      (rt),
        .branch_taken_i (br),
        .jump_i         (jmp),
        .dmem_req_i     (req),
        .dmem_ready_i   (ready),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .freeze_o       (freeze),
        .mem_err_o      (mem_err),
        .stall_cnt_o    (stall_cnt)
    );

    function automatic logic [4:0] act_vec();
        return {pc_write, ifid_write, ifid_flush, idex_bubble, freeze};
    endfunction

    function automatic logic [4:0] exp_vec();
        bit stall, lu;
        if (rst) return V_RESET;
        stall = (!m_wait && req && !ready) || (m_wait && !ready && (m_waited != TO - 1));
        lu    = memread && (rd != 0) && (rd == rs || rd == rt);
        if (stall)      return V_FREEZE;
        if (br || jmp)  return V_REDIR;
        if (lu)         return V_BUBBLE;
        return V_NORMAL;
    endfunction

    task automatic model_update();
        logic [4:0] v;
        if (rst) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_cnt = 0;
        end else begin
            v = exp_vec();
            if (!v[4] && m_cnt < MAXC) m_cnt++;
            if (!m_wait) begin
                if (req && !ready) begin m_wait = 1; m_waited = 0; end
            end else if (ready) begin
                m_wait = 0;
            end else if (m_waited == TO - 1) begin
                m_wait = 0; m_err = 1;
            end else begin
                m_waited++;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit mr, input int d, input int s, input int t,
                         input bit b, input bit j, input bit q, input bit y);
        rst = r; memread = mr; rd = 5'(d); rs = 5'(s); rt = 5'(t);
        br = b; jmp = j; req = q; ready = y;
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 1, 8, 8, 0, 1, 0, 1, 0);
        checks++;
        if (act_vec() !== V_RESET) begin
            errors++; $display("FAIL reset_outs: got %b expected %b", act_vec(), V_RESET);
        end
        tick();
        checks++;
        if (mem_err !== 1'b0 || stall_cnt !== '0) begin
            errors++; $display("FAIL reset_regs: got err=%b cnt=%0d expected err=0 cnt=0", mem_err, stall_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (act_vec() !== V_NORMAL) begin
            errors++; $display("FAIL idle_outs: got %b expected %b", act_vec(), V_NORMAL);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 1, 8, 8, 3, 0, 0, 0, 0);
        checks++;
        if (act_vec() !== V_BUBBLE) begin
            errors++; $display("FAIL load_use_stall: got %b expected %b", act_vec(), V_BUBBLE);
        end
        tick();
        drive(0, 0, 8, 8, 3, 0, 0, 0, 0);
        checks++;
        if (act_vec() !== V_NORMAL || stall_cnt !== 4'd1) begin
            errors++; $display("FAIL load_use_after: got %b cnt=%0d expected %b cnt=1", act_vec(), stall_cnt, V_NORMAL);
        end
        drive(0, 1, 9, 2, 9, 0, 0, 0, 0);
        checks++;
        if (act_vec() !== V_BUBBLE) begin
            errors++; $display("FAIL load_use_rt: got %b expected %b", act_vec(), V_BUBBLE);
        end
        tick();
    endtask

    task automatic test_rd_zero_redirect();
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (act_vec() !== V_NORMAL) begin
            errors++; $display("FAIL rd_zero: got %b expected %b", act_vec(), V_NORMAL);
        end
        drive(0, 1, 8, 8, 0, 1, 0, 0, 0);
        checks++;
        if (act_vec() !== V_REDIR) begin
            errors++; $display("FAIL branch_over_load_use: got %b expected %b", act_vec(), V_REDIR);
        end
        drive(0, 1, 8, 0, 8, 0, 1, 0, 0);
        checks++;
        if (act_vec() !== V_REDIR) begin
            errors++; $display("FAIL jump_over_load_use: got %b expected %b", act_vec(), V_REDIR);
        end
        tick();
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++; $display("FAIL redirect_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        int frz = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            if (freeze === 1'b1) frz++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (act_vec() !== V_NORMAL) begin
            errors++; $display("FAIL mem_release: got %b expected %b", act_vec(), V_NORMAL);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (frz != 3 || freeze !== 1'b0 || stall_cnt !== 4'd3 || mem_err !== 1'b0) begin
            errors++; $display("FAIL mem_wait: got frz=%0d now=%b cnt=%0d err=%b expected 3 0 3 0",
                               frz, freeze, stall_cnt, mem_err);
        end
    endtask

    task automatic test_zero_wait();
        int frz = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
            if (freeze !== 1'b0) frz++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        if (freeze !== 1'b0) frz++;
        tick();
        checks++;
        if (frz != 0 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL zero_wait: got frz=%0d cnt=%0d expected 0 0", frz, stall_cnt);
        end
    endtask

    task automatic test_timeout();
        int frz = 0;
        do_reset();
        for (int c = 0; c < TO; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            if (freeze === 1'b1) frz++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (frz != TO || freeze !== 1'b0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL timeout_release: got frz=%0d now=%b err=%b expected %0d 0 0",
                               frz, freeze, mem_err, TO);
        end
        tick();
        tick();
        checks++;
        if (mem_err !== 1'b1 || stall_cnt !== 4'(TO)) begin
            errors++; $display("FAIL timeout_err: got err=%b cnt=%0d expected 1 %0d", mem_err, stall_cnt, TO);
        end
        do_reset();
        checks++;
        if (mem_err !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %b expected 0", mem_err);
        end
    endtask

    task automatic test_freeze_redirect();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
            if (act_vec() !== V_FREEZE) bad++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0, 1, 1);
        checks++;
        if (bad != 0 || act_vec() !== V_REDIR) begin
            errors++; $display("FAIL freeze_then_flush: got bad=%0d now=%b expected 0 %b", bad, act_vec(), V_REDIR);
        end
        tick();
        for (int c = 0; c < TO - 1; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (act_vec() !== V_RESET) begin
            errors++; $display("FAIL reset_in_wait: got %b expected %b", act_vec(), V_RESET);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (freeze !== 1'b0 || stall_cnt !== 4'd0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL after_reset_wait: got frz=%b cnt=%0d err=%b expected 0 0 0",
                               freeze, stall_cnt, mem_err);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int c = 0; c < MAXC + 5; c++) begin
            drive(0, 1, 5, 5, 0, 0, 0, 0, 0);
            tick();
        end
        checks++;
        if (stall_cnt !== 4'(MAXC)) begin
            errors++; $display("FAIL saturate: got %0d expected %0d", stall_cnt, MAXC);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(39, 0) == 0, $urandom_range(1, 0) == 1,
                  $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(5, 0) == 0, $urandom_range(9, 0) == 0,
                  $urandom_range(2, 0) == 0, $urandom_range(9, 0) < 3);
            checks++;
            if (act_vec() !== exp_vec() || mem_err !== m_err || stall_cnt !== 4'(m_cnt)) begin
                errors++;
                $display("FAIL random[%0d]: got outs=%b err=%b cnt=%0d expected outs=%b err=%b cnt=%0d",
                         c, act_vec(), mem_err, stall_cnt, exp_vec(), m_err, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_rd_zero_redirect();
        test_mem_wait();
        test_zero_wait();
        test_timeout();
        test_freeze_redirect();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
